// File: rtl/stream_fifo_ctrl_if.sv
// stream_fifo_ctrl_if: valid/ready stream, flush and status bundle for stream_fifo_ctrl.
interface stream_fifo_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  logic flush_i;
  logic testmode_i;
  logic [DATA_WIDTH-1:0] data_i;
  logic valid_i;
  logic ready_o;
  logic [DATA_WIDTH-1:0] data_o;
  logic valid_o;
  logic ready_i;
  logic full_o;
  logic empty_o;
  logic [CntW-1:0] usage_o;
  modport master (
    output flush_i, testmode_i, data_i, valid_i, ready_i,
    input ready_o, data_o, valid_o, full_o, empty_o, usage_o
  );
  modport slave (
    input flush_i, testmode_i, data_i, valid_i, ready_i,
    output ready_o, data_o, valid_o, full_o, empty_o, usage_o
  );
endinterface

// File: rtl/stream_fifo_ctrl.sv
// stream_fifo_ctrl: register-based valid/ready FIFO with optional fall-through bypass when empty.
// Define STREAM_FIFO_ASSERTS_EN to compile in simulation-only depth and protocol checks.
module stream_fifo_ctrl #(
  parameter bit FALL_THROUGH = 1'b0,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH = 8,
  parameter type T = logic [DATA_WIDTH-1:0]
) (
  input logic clk_i,
  input logic rst_i,
  stream_fifo_ctrl_if.slave bus
);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);
  T mem_q [DEPTH];
  T mem_d [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic full, empty, bypass, valid_o, push, pop, wr_en, rd_en;
  T data_o;
  logic unused_testmode;
  assign unused_testmode = bus.testmode_i;
  // A bypassed word is consumed straight from the input, so storage is left alone.
  always_comb begin
    full = cnt_q == CntW'(DEPTH);
    empty = cnt_q == '0;
    bypass = FALL_THROUGH && empty;
    valid_o = bypass ? bus.valid_i : !empty;
    data_o = bypass ? bus.data_i : mem_q[rd_ptr_q];
    push = bus.valid_i && !full;
    pop = valid_o && bus.ready_i;
    wr_en = push && !(bypass && pop) && !bus.flush_i;
    rd_en = pop && !bypass && !bus.flush_i;
  end
  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[wr_ptr_q] = bus.data_i;
    wr_ptr_d = bus.flush_i ? '0 : !wr_en ? wr_ptr_q : (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
    rd_ptr_d = bus.flush_i ? '0 : !rd_en ? rd_ptr_q : (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
    cnt_d = bus.flush_i ? '0 : cnt_q + CntW'(wr_en) - CntW'(rd_en);
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q <= cnt_d;
    end
  end
  assign bus.ready_o = !full;
  assign bus.full_o = full;
  assign bus.empty_o = empty;
  assign bus.usage_o = cnt_q;
  assign bus.valid_o = valid_o;
  assign bus.data_o = data_o;
`ifdef STREAM_FIFO_ASSERTS_EN
  if (DEPTH == 0) begin : g_depth_chk
    $fatal(1, "stream_fifo_ctrl: DEPTH must be >= 1");
  end
  logic hold_q, hold_d;
  T hold_data_q, hold_data_d;
  // A stored word offered but not taken must stay put until it is popped.
  always_comb begin
    hold_d = valid_o && !bus.ready_i && !bypass && !bus.flush_i;
    hold_data_d = data_o;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hold_q <= 1'b0;
      hold_data_q <= '0;
    end else begin
      hold_q <= hold_d;
      hold_data_q <= hold_data_d;
      if (wr_en && full) $error("stream_fifo_ctrl: push while full");
      if (hold_q && (!valid_o || data_o != hold_data_q)) $error("stream_fifo_ctrl: output unstable before pop");
    end
  end
`else
  // Protocol checks compiled out; datapath is identical.
`endif
endmodule

// File: tb/tb_stream_fifo_ctrl.sv
// tb_stream_fifo_ctrl: three FIFOs (D4 registered, D4 fall-through, D3 registered) on shared
// stimulus, each compared every cycle against a queue model of the FIFO rules.
module tb_stream_fifo_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] din = '0;
  logic vin = 1'b0, rin = 1'b0, fl = 1'b0, tm = 1'b0;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;

  stream_fifo_ctrl_if #(.DATA_WIDTH(8), .DEPTH(4)) if0 ();
  stream_fifo_ctrl_if #(.DATA_WIDTH(8), .DEPTH(4)) if1 ();
  stream_fifo_ctrl_if #(.DATA_WIDTH(8), .DEPTH(3)) if2 ();

  stream_fifo_ctrl #(.FALL_THROUGH(1'b0), .DATA_WIDTH(8), .DEPTH(4)) dut0 (.clk_i(clk), .rst_i(rst), .bus(if0));
  stream_fifo_ctrl #(.FALL_THROUGH(1'b1), .DATA_WIDTH(8), .DEPTH(4)) dut1 (.clk_i(clk), .rst_i(rst), .bus(if1));
  stream_fifo_ctrl #(.FALL_THROUGH(1'b0), .DATA_WIDTH(8), .DEPTH(3)) dut2 (.clk_i(clk), .rst_i(rst), .bus(if2));

  assign if0.data_i = din;  assign if1.data_i = din;  assign if2.data_i = din;
  assign if0.valid_i = vin; assign if1.valid_i = vin; assign if2.valid_i = vin;
  assign if0.ready_i = rin; assign if1.ready_i = rin; assign if2.ready_i = rin;
  assign if0.flush_i = fl;  assign if1.flush_i = fl;  assign if2.flush_i = fl;
  assign if0.testmode_i = tm; assign if1.testmode_i = tm; assign if2.testmode_i = tm;

  logic rdy [3], vout [3], full [3], empty [3];
  logic [7:0] dout [3];
  logic [2:0] usage [3];
  assign rdy[0] = if0.ready_o;  assign rdy[1] = if1.ready_o;  assign rdy[2] = if2.ready_o;
  assign vout[0] = if0.valid_o; assign vout[1] = if1.valid_o; assign vout[2] = if2.valid_o;
  assign full[0] = if0.full_o;  assign full[1] = if1.full_o;  assign full[2] = if2.full_o;
  assign empty[0] = if0.empty_o; assign empty[1] = if1.empty_o; assign empty[2] = if2.empty_o;
  assign dout[0] = if0.data_o;  assign dout[1] = if1.data_o;  assign dout[2] = if2.data_o;
  assign usage[0] = if0.usage_o; assign usage[1] = if1.usage_o; assign usage[2] = {1'b0, if2.usage_o};

  int dep [3] = '{4, 4, 3};
  bit ft [3] = '{1'b0, 1'b1, 1'b0};
  logic [7:0] mq [3][$];

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_ready%0d", i), rdy[i], 1);
      check($sformatf("rst_full%0d", i), full[i], 0);
      check($sformatf("rst_empty%0d", i), empty[i], 1);
      check($sformatf("rst_usage%0d", i), usage[i], 0);
      check($sformatf("rst_valid%0d", i), vout[i], ft[i] ? vin : 0);
      check($sformatf("rst_data%0d", i), dout[i], ft[i] ? din : 0);
    end
  endtask

  task automatic step(input bit v, input logic [7:0] d, input bit r, input bit f);
    bit push [3], pop [3], byp [3];
    @(negedge clk);
    vin = v; din = d; rin = r; fl = f; tm = 1'($urandom);
    #1;
    for (int i = 0; i < 3; i++) begin
      int n = mq[i].size();
      bit e = (n == 0);
      bit fu = (n == dep[i]);
      bit b = ft[i] && e;
      bit ev = b ? v : !e;
      check($sformatf("ready%0d", i), rdy[i], !fu);
      check($sformatf("full%0d", i), full[i], fu);
      check($sformatf("empty%0d", i), empty[i], e);
      check($sformatf("usage%0d", i), usage[i], n);
      check($sformatf("valid%0d", i), vout[i], ev);
      if (ev) check($sformatf("data%0d", i), dout[i], b ? d : mq[i][0]);
      push[i] = v && !fu;
      pop[i] = ev && r;
      byp[i] = b;
    end
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (f) mq[i].delete();
      else if (!(byp[i] && push[i] && pop[i])) begin
        if (pop[i]) void'(mq[i].pop_front());
        if (push[i]) mq[i].push_back(d);
      end
    end
  endtask

  initial begin
    vin = 1'b1; din = 8'h3C;
    #12;
    check_reset();
    @(negedge clk);
    vin = 1'b0; din = '0;
    rst = 1'b0;
    // Fill: A1..A4 back-to-back with the consumer stalled, then drain in order.
    for (int k = 1; k <= 4; k++) step(1'b1, 8'hA0 + 8'(k), 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) step(1'b0, 8'h00, 1'b1, 1'b0);
    // Empty with simultaneous offer and accept: fall-through instance bypasses.
    step(1'b1, 8'h55, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) step(1'b0, 8'h00, 1'b1, 1'b0);
    // Full with push and pop together: pop happens, new word is dropped.
    for (int k = 0; k < 4; k++) step(1'b1, 8'hB0 + 8'(k), 1'b0, 1'b0);
    step(1'b1, 8'hC0, 1'b1, 1'b0);
    step(1'b1, 8'hC1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) step(1'b0, 8'h00, 1'b1, 1'b0);
    // Flush at usage 2 with a concurrent push.
    step(1'b1, 8'hD0, 1'b0, 1'b0);
    step(1'b1, 8'hD1, 1'b0, 1'b0);
    step(1'b1, 8'hD2, 1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    for (int k = 0; k < 600; k++)
      step($urandom_range(3, 0) != 0, 8'($urandom), $urandom_range(2, 0) != 0, $urandom_range(39, 0) == 0);
    for (int k = 0; k < 3; k++) step(1'b1, 8'hE0 + 8'(k), 1'b0, 1'b0);
    // Asynchronous reset mid-stream, sampled well before the next rising edge.
    @(negedge clk);
    vin = 1'b1; din = 8'h7E; rin = 1'b0;
    #2 rst = 1'b1;
    #1 check_reset();
    for (int i = 0; i < 3; i++) mq[i].delete();
    @(negedge clk);
    vin = 1'b0; din = '0;
    rst = 1'b0;
    for (int k = 0; k < 60; k++)
      step($urandom_range(1, 0) != 0, 8'($urandom), $urandom_range(3, 0) != 0, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
